// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with zero-cycle hits and 4-word block refill
module icache_dm #(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_read,
  input  logic [ADDR_W-1:0] proc_addr,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state;
  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0] tag_arr [NUM_BLOCKS];
  logic [127:0] data_arr [NUM_BLOCKS];
  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag;
  logic hit;
  assign idx = proc_addr[IDX_W+1:2];
  assign tag = proc_addr[ADDR_W-1:IDX_W+2];
  // the refill targets the line named by the latched block address, not the live core address
  assign fill_idx = mem_addr[IDX_W-1:0];
  assign hit = proc_read & valid[idx] & (tag_arr[idx] == tag);
  assign proc_rdata = data_arr[idx][{proc_addr[1:0], 5'd0} +: 32];
  assign proc_stall = (state == FETCH) | (proc_read & ~hit);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid    <= '0;
      mem_read <= 1'b0;
      mem_addr <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE) begin
      if (hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (proc_read && !hit) begin
        state    <= FETCH;
        mem_read <= 1'b1;
        mem_addr <= proc_addr[ADDR_W-1:2];
        miss_cnt <= (miss_cnt != 16'hFFFF) ? miss_cnt + 16'd1 : miss_cnt;
      end
    end else if (mem_ready) begin
      data_arr[fill_idx] <= mem_rdata;
      tag_arr[fill_idx]  <= mem_addr[ADDR_W-3:IDX_W];
      valid[fill_idx]    <= 1'b1;
      state              <= IDLE;
      mem_read           <= 1'b0;
    end
  end
endmodule
